// File: rtl/l2_rsp_matcher.sv
// Response-side matcher for the L2 request buffer: pairs coherence responses with
// outstanding slots by (tag,set), counts invalidation acks and retires completed slots.
module l2_rsp_matcher #(
  parameter int N_ENTRIES = 4,
  parameter int TAG_W     = 20,
  parameter int SET_W     = 8,
  parameter int CNT_W     = 5,
  parameter int LINE_W    = 128,
  localparam int IDX_W    = $clog2(N_ENTRIES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_valid,
  input  logic [IDX_W-1:0]     alloc_idx,
  input  logic [TAG_W-1:0]     alloc_tag,
  input  logic [SET_W-1:0]     alloc_set,
  input  logic                 alloc_putack,
  input  logic                 rsp_valid,
  output logic                 rsp_ready,
  input  logic [1:0]           rsp_coh_msg,
  input  logic [TAG_W-1:0]     rsp_tag,
  input  logic [SET_W-1:0]     rsp_set,
  input  logic [CNT_W-1:0]     rsp_invack_cnt,
  input  logic [LINE_W-1:0]    rsp_line,
  output logic                 done_valid,
  input  logic                 done_ready,
  output logic [IDX_W-1:0]     done_idx,
  output logic                 done_excl,
  output logic [LINE_W-1:0]    done_line,
  output logic [N_ENTRIES-1:0] busy,
  output logic                 err_unmatched
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_DATA,
    ST_WAIT_PUTACK,
    ST_COMPLETE
  } slot_state_e;

  localparam logic [1:0] MSG_DATA   = 2'd0;
  localparam logic [1:0] MSG_EDATA  = 2'd1;
  localparam logic [1:0] MSG_INVACK = 2'd2;
  localparam logic [1:0] MSG_PUTACK = 2'd3;

  slot_state_e       slotState_q [N_ENTRIES];
  slot_state_e       slotState_d [N_ENTRIES];
  logic [TAG_W-1:0]  tag_q       [N_ENTRIES];
  logic [TAG_W-1:0]  tag_d       [N_ENTRIES];
  logic [SET_W-1:0]  set_q       [N_ENTRIES];
  logic [SET_W-1:0]  set_d       [N_ENTRIES];
  logic [CNT_W-1:0]  cnt_q       [N_ENTRIES];
  logic [CNT_W-1:0]  cnt_d       [N_ENTRIES];
  logic              seen_q      [N_ENTRIES];
  logic              seen_d      [N_ENTRIES];
  logic              excl_q      [N_ENTRIES];
  logic              excl_d      [N_ENTRIES];
  logic [LINE_W-1:0] line_q      [N_ENTRIES];
  logic [LINE_W-1:0] line_d      [N_ENTRIES];

  logic              doneValid_q, doneValid_d;
  logic [IDX_W-1:0]  doneIdx_q, doneIdx_d;
  logic              doneExcl_q, doneExcl_d;
  logic [LINE_W-1:0] doneLine_q, doneLine_d;
  logic              errUnmatched_q, errUnmatched_d;

  logic [N_ENTRIES-1:0] hit;
  logic [IDX_W-1:0]     hitIdx;
  logic                 anyHit;
  logic                 accept;
  logic                 retire;
  logic                 isData;
  logic [CNT_W-1:0]     updCnt;
  logic                 updSeen;
  logic                 completes;
  logic                 allocOk;

  assign rsp_ready     = !doneValid_q || done_ready;
  assign accept        = rsp_valid && rsp_ready;
  assign retire        = doneValid_q && done_ready;
  assign isData        = (rsp_coh_msg == MSG_DATA) || (rsp_coh_msg == MSG_EDATA);
  assign done_valid    = doneValid_q;
  assign done_idx      = doneIdx_q;
  assign done_excl     = doneExcl_q;
  assign done_line     = doneLine_q;
  assign err_unmatched = errUnmatched_q;

  // A slot only matches messages it can legally consume; anything else is unmatched.
  always_comb begin
    hit = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      busy[i] = (slotState_q[i] != ST_IDLE);
      if (tag_q[i] == rsp_tag && set_q[i] == rsp_set) begin
        if (slotState_q[i] == ST_WAIT_DATA && rsp_coh_msg != MSG_PUTACK)
          hit[i] = 1'b1;
        if (slotState_q[i] == ST_WAIT_PUTACK && rsp_coh_msg == MSG_PUTACK)
          hit[i] = 1'b1;
      end
    end
  end

  always_comb begin
    hitIdx = '0;
    anyHit = 1'b0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hitIdx = IDX_W'(i);
        anyHit = 1'b1;
      end
    end
  end

  // Counter may dip negative when invacks overtake the data response.
  always_comb begin
    updCnt    = isData ? (cnt_q[hitIdx] + rsp_invack_cnt) : (cnt_q[hitIdx] - CNT_W'(1));
    updSeen   = seen_q[hitIdx] || isData;
    completes = (slotState_q[hitIdx] == ST_WAIT_PUTACK) || (updSeen && updCnt == '0);
    allocOk   = alloc_valid &&
                (slotState_q[alloc_idx] == ST_IDLE || (retire && doneIdx_q == alloc_idx));
  end

  always_comb begin
    slotState_d    = slotState_q;
    tag_d          = tag_q;
    set_d          = set_q;
    cnt_d          = cnt_q;
    seen_d         = seen_q;
    excl_d         = excl_q;
    line_d         = line_q;
    doneValid_d    = retire ? 1'b0 : doneValid_q;
    doneIdx_d      = doneIdx_q;
    doneExcl_d     = doneExcl_q;
    doneLine_d     = doneLine_q;
    errUnmatched_d = accept && !anyHit;

    if (retire)
      slotState_d[doneIdx_q] = ST_IDLE;

    // Only one response per cycle, so at most one slot can complete per cycle.
    if (accept && anyHit) begin
      cnt_d[hitIdx]  = updCnt;
      seen_d[hitIdx] = updSeen;
      if (isData) begin
        line_d[hitIdx] = rsp_line;
        excl_d[hitIdx] = (rsp_coh_msg == MSG_EDATA);
      end
      if (completes) begin
        slotState_d[hitIdx] = ST_COMPLETE;
        doneValid_d         = 1'b1;
        doneIdx_d           = hitIdx;
        if (rsp_coh_msg == MSG_PUTACK) begin
          doneExcl_d = 1'b0;
          doneLine_d = '0;
        end else if (isData) begin
          doneExcl_d = (rsp_coh_msg == MSG_EDATA);
          doneLine_d = rsp_line;
        end else begin
          doneExcl_d = excl_q[hitIdx];
          doneLine_d = line_q[hitIdx];
        end
      end
    end

    if (allocOk) begin
      slotState_d[alloc_idx] = alloc_putack ? ST_WAIT_PUTACK : ST_WAIT_DATA;
      tag_d[alloc_idx]       = alloc_tag;
      set_d[alloc_idx]       = alloc_set;
      cnt_d[alloc_idx]       = '0;
      seen_d[alloc_idx]      = 1'b0;
      excl_d[alloc_idx]      = 1'b0;
      line_d[alloc_idx]      = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        slotState_q[i] <= ST_IDLE;
        tag_q[i]       <= '0;
        set_q[i]       <= '0;
        cnt_q[i]       <= '0;
        seen_q[i]      <= 1'b0;
        excl_q[i]      <= 1'b0;
        line_q[i]      <= '0;
      end
      doneValid_q    <= 1'b0;
      doneIdx_q      <= '0;
      doneExcl_q     <= 1'b0;
      doneLine_q     <= '0;
      errUnmatched_q <= 1'b0;
    end else begin
      slotState_q    <= slotState_d;
      tag_q          <= tag_d;
      set_q          <= set_d;
      cnt_q          <= cnt_d;
      seen_q         <= seen_d;
      excl_q         <= excl_d;
      line_q         <= line_d;
      doneValid_q    <= doneValid_d;
      doneIdx_q      <= doneIdx_d;
      doneExcl_q     <= doneExcl_d;
      doneLine_q     <= doneLine_d;
      errUnmatched_q <= errUnmatched_d;
    end
  end

endmodule
